// File: rtl/dmem_refill_responder_if.sv
// Request/done handshake between the data cache (master) and the
// memory-side refill responder (slave).
interface dmem_refill_responder_if;
    logic        req;
    logic        wren;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata1;
    logic [31:0] rdata0;

    modport master (
        output req, wren, addr, wdata,
        input  busy, done, rdata1, rdata0
    );

    modport slave (
        input  req, wren, addr, wdata,
        output busy, done, rdata1, rdata0
    );
endinterface

// File: rtl/dmem_refill_responder.sv
// Memory-side responder for data cache misses and writes.
// Accepts one request at a time and waits LATENCY edges before returning it.
// It then returns the aligned 2-word block that contains the addressed word.
// Optional feature macro: DMEM_REFILL_STATS_EN adds a 32-bit req_count output
// counting completed requests.
module dmem_refill_responder #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    dmem_refill_responder_if.slave    bus
`ifdef DMEM_REFILL_STATS_EN
    ,
    output logic [31:0]               req_count
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [3:0]          cnt;
    logic [3:0]          cnt_next;
    logic                accept;
    logic                finish;

    logic [ADDR_W-1:0]   lat_idx;
    logic                lat_wren;
    logic [31:0]         lat_wdata;

    logic [31:0]         mem [0:(2**ADDR_W)-1];
    logic [31:0]         rdata0_q;
    logic [31:0]         rdata1_q;
    logic                busy_q;
    logic                done_q;

    logic [ADDR_W-1:0]   req_idx;
    logic [ADDR_W-1:0]   even_idx;
    logic [ADDR_W-1:0]   odd_idx;
    logic                unused_addr_bits;

    // Byte address to word index; upper bits alias and byte offset is dropped.
    assign req_idx          = bus.addr[ADDR_W+1:2];
    assign unused_addr_bits = ^{bus.addr[31:ADDR_W+2], bus.addr[1:0]};
    assign even_idx         = {lat_idx[ADDR_W-1:1], 1'b0};
    assign odd_idx          = {lat_idx[ADDR_W-1:1], 1'b1};

    // Next-state and latency counter logic; requests are only looked at in IDLE.
    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req) begin
                    accept     = 1'b1;
                    cnt_next   = 4'(LATENCY - 1);
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    finish     = 1'b1;
                    next_state = DONE;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State register and counter; reset abandons any request in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
        end
    end

    // busy and done are flopped from next_state so they are glitch-free.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= (next_state != IDLE);
            done_q <= (next_state == DONE);
        end
    end

    // Capture the request when it is accepted so the cache may change its inputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            lat_idx   <= '0;
            lat_wren  <= 1'b0;
            lat_wdata <= 32'd0;
        end else if (accept) begin
            lat_idx   <= req_idx;
            lat_wren  <= bus.wren;
            lat_wdata <= bus.wdata;
        end
    end

    // Storage is not reset; a write lands only on the edge that completes the wait.
    always_ff @(posedge clk) begin
        if (rst && finish && lat_wren) begin
            mem[lat_idx] <= lat_wdata;
        end
    end

    // Load the block on completion; the word being written is forwarded into it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata0_q <= 32'd0;
            rdata1_q <= 32'd0;
        end else if (finish) begin
            rdata0_q <= (lat_wren && !lat_idx[0]) ? lat_wdata : mem[even_idx];
            rdata1_q <= (lat_wren &&  lat_idx[0]) ? lat_wdata : mem[odd_idx];
        end
    end

`ifdef DMEM_REFILL_STATS_EN
    // Count completed requests; wraps naturally at 32 bits.
    always_ff @(posedge clk) begin
        if (!rst) begin
            req_count <= 32'd0;
        end else if (finish) begin
            req_count <= req_count + 32'd1;
        end
    end
`endif

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.rdata0 = rdata0_q;
    assign bus.rdata1 = rdata1_q;

endmodule
